// File: rtl/timer_set_ctrl.sv
// Set-mode controller for a BCD timer: debounces three push-buttons and turns their presses
// into increment/load strobes and a digit selector. Optional macro AUTO_REPEAT_INC_EN adds increment auto-repeat.
module timer_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 20000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       swt,
    input  logic       btn_inc_i,
    input  logic       btn_next_i,
    input  logic       btn_load_i,
    output logic       ib_o,
    output logic       sb_o,
    output logic [2:0] digit_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    localparam int BTN_INC  = 0;
    localparam int BTN_NEXT = 1;
    localparam int BTN_LOAD = 2;

    localparam logic [2:0] DIGIT_FIRST = 3'b001;
    localparam logic [2:0] DIGIT_LAST  = 3'b110;

    logic [2:0]       raw;
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       deb_q, deb_d, deb_prev_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       rise;
    logic             ib_q, ib_d, sb_q, sb_d, nb_q, nb_d;
    logic [2:0]       digit_q, digit_d;
    logic             rep_pulse;

    assign raw = {btn_load_i, btn_next_i, btn_inc_i};

    // Per-button debounce: a level is accepted only after it differs from the
    // accepted level on DEBOUNCE_CYCLES+1 consecutive edges.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        for (int b = 0; b < 3; b++) begin
            deb_d[b] = deb_q[b];
            cnt_d[b] = '0;
            if (sync2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == DEB_MAX) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

`ifdef AUTO_REPEAT_INC_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_C  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PERIOD_C = REP_W'(REPEAT_PERIOD);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;

    // rep_cnt_q counts cycles since the last inc strobe; zero means idle.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_pulse   = 1'b0;
        if (!deb_q[BTN_INC] || swt) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (rise[BTN_INC]) begin
            rep_cnt_d   = REP_W'(1);
            rep_first_d = 1'b1;
        end else if (rep_cnt_q != '0) begin
            if (rep_cnt_q == (rep_first_q ? REP_DELAY_C : REP_PERIOD_C)) begin
                rep_pulse   = 1'b1;
                rep_cnt_d   = REP_W'(1);
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    always_comb begin
        ib_d    = (rise[BTN_INC] & ~swt) | rep_pulse;
        sb_d    = rise[BTN_LOAD] & ~swt;
        nb_d    = rise[BTN_NEXT] & ~swt;
        digit_d = digit_q;
        // The advance lands one cycle after the strobe so a coincident ib_o sees the old digit.
        if (nb_q) begin
            digit_d = (digit_q >= DIGIT_LAST || digit_q == 3'b000) ? DIGIT_FIRST : digit_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
            ib_q       <= 1'b0;
            sb_q       <= 1'b0;
            nb_q       <= 1'b0;
            digit_q    <= DIGIT_FIRST;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int b = 0; b < 3; b++) cnt_q[b] <= cnt_d[b];
            ib_q       <= ib_d;
            sb_q       <= sb_d;
            nb_q       <= nb_d;
            digit_q    <= digit_d;
        end
    end

    assign ib_o    = ib_q;
    assign sb_o    = sb_q;
    assign digit_o = digit_q;

endmodule

// File: doc/timer_set_ctrl.md
TIMER_SET_CTRL -- requirements
Module: timer_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive cycles a synchronized button level must hold before it is accepted.
REQ-002 Parameter REPEAT_DELAY, default 50000000: cycles from the first increment pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 20000000: cycles between consecutive auto-repeat pulses.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 swt  input  1  run switch; 1 = timer running (set controls locked), 0 = set mode.
REQ-007 btn_inc_i  input  1  raw, asynchronous increment push-button, active-high.
REQ-008 btn_next_i  input  1  raw, asynchronous digit-select push-button, active-high.
REQ-009 btn_load_i  input  1  raw, asynchronous load/restore push-button, active-high.
REQ-010 ib_o  output  1  one-cycle increment strobe for the selected digit.
REQ-011 sb_o  output  1  one-cycle load strobe (restore stored set value).
REQ-012 digit_o  output  3  selected BCD digit, 3'b001 (seconds units) .. 3'b110 (tens of hours).

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each button SHALL have its own debounce counter (width ceil(log2(DEBOUNCE_CYCLES+1))) and a debounced-level register.
REQ-015 Counter SHALL clear whenever the synchronized level equals the debounced level; otherwise it increments.
REQ-016 When the counter reaches DEBOUNCE_CYCLES, the debounced level SHALL take the synchronized level and the counter SHALL clear.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no debounced change and no strobe.
REQ-018 A debounced 0->1 edge SHALL produce a registered one-cycle strobe; latency from the first clk edge sampling the new raw level to the strobe being high SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-019 Debounced 1->0 edges SHALL produce no strobe.
REQ-020 Rising inc edge with swt=0 -> ib_o=1 for one cycle; rising load edge with swt=0 -> sb_o=1 for one cycle.
REQ-021 Rising next edge with swt=0 -> digit_o advances by 1 on the following cycle; 3'b110 wraps to 3'b001.
REQ-022 digit_o SHALL never hold 3'b000 or 3'b111.
REQ-023 While swt=1: ib_o=0, sb_o=0, digit_o held; presses are debounced but discarded, with no deferred strobe when swt returns to 0.
REQ-024 Inc and next edges in the same cycle: ib_o SHALL be asserted with the pre-advance digit_o value; the advance is visible on the next cycle.
REQ-025 Inc and load edges in the same cycle: ib_o and sb_o SHALL both be asserted in that cycle.
REQ-026 ib_o and sb_o SHALL each be high for at most one consecutive cycle per press, except for auto-repeat (REQ-030).

Reset
REQ-027 While reset=1, the block SHALL asynchronously force: ib_o=0, sb_o=0, digit_o=3'b001, synchronizers=0, debounced levels=0, all counters=0.
REQ-028 A button already held when reset deasserts SHALL be treated as a new press: one strobe after DEBOUNCE_CYCLES+3 cycles.
REQ-029 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no strobe emitted.

Configuration
REQ-030 Macro AUTO_REPEAT_INC_EN defined: while the debounced inc level is 1 and swt=0, an extra ib_o pulse SHALL occur REPEAT_DELAY cycles after the initial strobe, then every REPEAT_PERIOD cycles.
REQ-031 Under AUTO_REPEAT_INC_EN: inc release or swt=1 SHALL clear the repeat counter immediately; no further pulses follow.
REQ-032 Macro AUTO_REPEAT_INC_EN undefined: no repeat counter is built and ib_o pulses exactly once per debounced press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-033 Reset, then btn_next_i pressed 6 times with swt=0 -> digit_o sequence 1,2,3,4,5,6,1.
REQ-034 btn_inc_i high 3 cycles then low -> no ib_o; btn_inc_i held high -> ib_o high exactly at cycle 7 after first sample, one cycle wide.
REQ-035 swt=1, press inc/next/load, then swt=0 -> ib_o=sb_o=0 throughout, digit_o unchanged.
REQ-036 btn_inc_i and btn_next_i rise together at digit 6 -> ib_o pulse with digit_o=6, next cycle digit_o=1.
REQ-037 AUTO_REPEAT_INC_EN defined, inc held 50 cycles after the first strobe -> repeat pulses 20, 28, 36, 44 cycles after it; macro undefined -> single pulse.
REQ-038 Reset pulse asserted 2 cycles into an inc debounce -> outputs at reset values, no ib_o; inc still held -> ib_o 7 cycles after reset release.
